// File: rtl/sr_mc_control.sv
// Multicycle control sequencer for schoolRISCV: fetch/decode/exec/writeback with a sticky trap.
// Optional retired-instruction counter enabled by SR_MC_INSTR_COUNT_EN.

`ifndef ALU_ADD
`define ALU_ADD  3'b000
`define ALU_OR   3'b001
`define ALU_SRL  3'b010
`define ALU_SLTU 3'b011
`define ALU_SUB  3'b100
`endif

module sr_mc_control #(
  parameter int unsigned IMEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       imemReq,
  input  logic       imemAck,
  input  logic [6:0] cmdOp,
  input  logic [2:0] cmdF3,
  input  logic [6:0] cmdF7,
  input  logic       aluZero,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       regWrite,
  output logic       aluSrc,
  output logic       wdSrc,
  output logic [2:0] aluControl,
  output logic [1:0] fault,
  output logic       busy
`ifdef SR_MC_INSTR_COUNT_EN
  ,
  output logic [31:0] instrCount
`endif
);

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    I_ILLEGAL, I_ADD, I_SUB, I_OR, I_SRL, I_SLTU, I_ADDI, I_LUI, I_BEQ, I_BNE, I_JAL
  } instr_t;

  localparam logic [7:0] TMO_LAST = 8'(IMEM_TIMEOUT - 1);

  state_t      state, stateNext;
  instr_t      instr;
  logic [6:0]  irOp;
  logic [2:0]  irF3;
  logic [6:0]  irF7;
  logic [7:0]  tmoCnt;
  logic [1:0]  faultR, faultSet;
  logic        latchIr, tmoInc;
  logic [2:0]  decAlu;
  logic        decAluSrc, decRegW, decWd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RESET;
      irOp   <= '0;
      irF3   <= '0;
      irF7   <= '0;
      tmoCnt <= '0;
      faultR <= '0;
    end else begin
      state <= stateNext;
      if (latchIr) begin
        irOp <= cmdOp;
        irF3 <= cmdF3;
        irF7 <= cmdF7;
      end
      // Counter is only meaningful while fetching, so it is cleared everywhere else.
      if (state != S_FETCH)
        tmoCnt <= '0;
      else if (tmoInc)
        tmoCnt <= tmoCnt + 8'd1;
      if (faultSet != 2'b00)
        faultR <= faultSet;
    end
  end

  always_comb begin
    instr = I_ILLEGAL;
    casez ({irF7, irF3, irOp})
      17'b0000000_000_0110011: instr = I_ADD;
      17'b0100000_000_0110011: instr = I_SUB;
      17'b0000000_110_0110011: instr = I_OR;
      17'b0000000_101_0110011: instr = I_SRL;
      17'b0000000_011_0110011: instr = I_SLTU;
      17'b???????_000_0010011: instr = I_ADDI;
      17'b???????_???_0110111: instr = I_LUI;
      17'b???????_000_1100011: instr = I_BEQ;
      17'b???????_001_1100011: instr = I_BNE;
      17'b???????_???_1101111: instr = I_JAL;
      default:                 instr = I_ILLEGAL;
    endcase
  end

  always_comb begin
    decAlu    = `ALU_ADD;
    decAluSrc = 1'b0;
    decRegW   = 1'b0;
    decWd     = 1'b0;
    case (instr)
      I_ADD:  begin decAlu = `ALU_ADD;  decRegW = 1'b1; end
      I_SUB:  begin decAlu = `ALU_SUB;  decRegW = 1'b1; end
      I_OR:   begin decAlu = `ALU_OR;   decRegW = 1'b1; end
      I_SRL:  begin decAlu = `ALU_SRL;  decRegW = 1'b1; end
      I_SLTU: begin decAlu = `ALU_SLTU; decRegW = 1'b1; end
      I_ADDI: begin decAluSrc = 1'b1;   decRegW = 1'b1; end
      I_LUI:  begin decRegW = 1'b1;     decWd = 1'b1;   end
      I_BEQ, I_BNE: decAlu = `ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    stateNext  = state;
    imemReq    = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 2'd0;
    regWrite   = 1'b0;
    aluSrc     = 1'b0;
    wdSrc      = 1'b0;
    aluControl = `ALU_ADD;
    busy       = 1'b1;
    latchIr    = 1'b0;
    tmoInc     = 1'b0;
    faultSet   = 2'b00;
    case (state)
      S_RESET: begin
        busy      = 1'b0;
        stateNext = S_FETCH;
      end
      S_FETCH: begin
        imemReq = 1'b1;
        irWrite = imemAck;
        // An ack in the limit cycle takes priority over the timeout.
        if (imemAck) begin
          latchIr   = 1'b1;
          stateNext = S_DECODE;
        end else if (tmoCnt == TMO_LAST) begin
          faultSet  = 2'b10;
          stateNext = S_TRAP;
        end else begin
          tmoInc = 1'b1;
        end
      end
      S_DECODE: begin
        if (instr == I_ILLEGAL) begin
          faultSet  = 2'b01;
          stateNext = S_TRAP;
        end else begin
          stateNext = S_EXEC;
        end
      end
      S_EXEC: begin
        aluControl = decAlu;
        aluSrc     = decAluSrc;
        stateNext  = S_WB;
      end
      S_WB: begin
        aluControl = decAlu;
        aluSrc     = decAluSrc;
        regWrite   = decRegW;
        wdSrc      = decWd;
        pcWrite    = 1'b1;
        case (instr)
          I_BEQ:   pcSrc = aluZero ? 2'd1 : 2'd0;
          I_BNE:   pcSrc = aluZero ? 2'd0 : 2'd1;
          I_JAL:   pcSrc = 2'd2;
          default: pcSrc = 2'd0;
        endcase
        stateNext = S_FETCH;
      end
      S_TRAP: busy = 1'b0;
      default: begin
        busy      = 1'b0;
        stateNext = S_RESET;
      end
    endcase
  end

  assign fault = faultR;

`ifdef SR_MC_INSTR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instrCount <= '0;
    else if (state == S_WB)
      instrCount <= instrCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sr_mc_control.sv
// Self-checking bench for sr_mc_control: directed scenarios then randomized instruction
// streams checked cycle by cycle against a pattern-table reference model.
`timescale 1ns/1ps

module tb_sr_mc_control;

  localparam int unsigned TMO = 4;
  localparam logic [2:0] A_ADD = 3'b000, A_OR = 3'b001, A_SRL = 3'b010,
                         A_SLTU = 3'b011, A_SUB = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imemReq, imemAck = 1'b0;
  logic [6:0]  cmdOp = '0;
  logic [2:0]  cmdF3 = '0;
  logic [6:0]  cmdF7 = '0;
  logic        aluZero = 1'b0;
  logic        irWrite, pcWrite, regWrite, aluSrc, wdSrc, busy;
  logic [1:0]  pcSrc, fault;
  logic [2:0]  aluControl;
`ifdef SR_MC_INSTR_COUNT_EN
  logic [31:0] instrCount;
`endif

  sr_mc_control #(.IMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAck(imemAck),
    .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7), .aluZero(aluZero),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
    .aluSrc(aluSrc), .wdSrc(wdSrc), .aluControl(aluControl), .fault(fault),
    .busy(busy)
`ifdef SR_MC_INSTR_COUNT_EN
    , .instrCount(instrCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // One row per legal instruction: field pattern, care mask and expected controls.
  // pcKind: 0 sequential, 1 BEQ, 2 BNE, 3 JAL.
  typedef struct {
    logic [16:0] val;
    logic [16:0] mask;
    logic [2:0]  alu;
    logic        aSrc;
    logic        regW;
    logic        wd;
    int          pcKind;
  } pat_t;

  pat_t        pats[10];
  logic [1:0]  faultM;
  bit          trapped;
  int unsigned retired;

  logic [13:0] obsV;
  assign obsV = {imemReq, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc,
                 aluControl, fault, busy};

  function automatic logic [13:0] expv(logic req, logic irw, logic pcw, logic [1:0] pcs,
                                       logic rw, logic as, logic wd, logic [2:0] alu,
                                       logic [1:0] flt, logic bsy);
    return {req, irw, pcw, pcs, rw, as, wd, alu, flt, bsy};
  endfunction

  function automatic int classify(logic [16:0] f);
    for (int i = 0; i < 10; i++)
      if ((f & pats[i].mask) == pats[i].val) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmpCycle(input string tag, input logic [13:0] exp);
    chk(tag, {18'd0, obsV}, {18'd0, exp});
`ifdef SR_MC_INSTR_COUNT_EN
    chk({tag, "_count"}, instrCount, retired);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randCmd();
    {cmdF7, cmdF3, cmdOp} = 17'($urandom);
  endtask

  task automatic resetSeq();
    rst_n = 1'b0;
    imemAck = 1'b0;
    faultM = 2'b00;
    trapped = 0;
    retired = 0;
    #1;
    cmpCycle("reset_asserted", expv(0, 0, 0, 2'd0, 0, 0, 0, A_ADD, 2'b00, 0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    cmpCycle("s_reset", expv(0, 0, 0, 2'd0, 0, 0, 0, A_ADD, 2'b00, 0));
    tick();
  endtask

  task automatic trapIdle(input int n);
    for (int i = 0; i < n; i++) begin
      imemAck = 1'($urandom);
      randCmd();
      @(negedge clk);
      cmpCycle("trap", expv(0, 0, 0, 2'd0, 0, 0, 0, A_ADD, faultM, 0));
      tick();
    end
  endtask

  task automatic runInstr(input logic [16:0] fields, input int waitC, input logic zero,
                          input bit abortExec);
    int idx;
    logic ack;
    logic [1:0] pcs;
    idx = classify(fields);
    for (int w = 0; w <= waitC; w++) begin
      ack = (w == waitC);
      imemAck = ack;
      if (ack) {cmdF7, cmdF3, cmdOp} = fields;
      else randCmd();
      @(negedge clk);
      cmpCycle("fetch", expv(1, ack, 0, 2'd0, 0, 0, 0, A_ADD, faultM, 1));
      tick();
      if (!ack && w == int'(TMO) - 1) begin
        trapped = 1;
        faultM = 2'b10;
        imemAck = 1'b0;
        return;
      end
    end
    imemAck = 1'($urandom);
    randCmd();
    @(negedge clk);
    cmpCycle("decode", expv(0, 0, 0, 2'd0, 0, 0, 0, A_ADD, faultM, 1));
    tick();
    if (idx < 0) begin
      trapped = 1;
      faultM = 2'b01;
      return;
    end
    randCmd();
    aluZero = 1'($urandom);
    @(negedge clk);
    cmpCycle("exec", expv(0, 0, 0, 2'd0, 0, pats[idx].aSrc, 0, pats[idx].alu, faultM, 1));
    if (abortExec) begin
      resetSeq();
      return;
    end
    tick();
    aluZero = zero;
    case (pats[idx].pcKind)
      1:       pcs = zero ? 2'd1 : 2'd0;
      2:       pcs = zero ? 2'd0 : 2'd1;
      3:       pcs = 2'd2;
      default: pcs = 2'd0;
    endcase
    @(negedge clk);
    cmpCycle("wb", expv(0, 0, 1, pcs, pats[idx].regW, pats[idx].aSrc, pats[idx].wd,
                        pats[idx].alu, faultM, 1));
    tick();
    retired++;
  endtask

  function automatic logic [16:0] legalRand(int i);
    logic [16:0] r;
    r = 17'($urandom);
    return (r & ~pats[i].mask) | pats[i].val;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] f;
    int w;
    pats[0] = '{17'b0000000_000_0110011, 17'h1FFFF, A_ADD,  1'b0, 1'b1, 1'b0, 0};
    pats[1] = '{17'b0100000_000_0110011, 17'h1FFFF, A_SUB,  1'b0, 1'b1, 1'b0, 0};
    pats[2] = '{17'b0000000_110_0110011, 17'h1FFFF, A_OR,   1'b0, 1'b1, 1'b0, 0};
    pats[3] = '{17'b0000000_101_0110011, 17'h1FFFF, A_SRL,  1'b0, 1'b1, 1'b0, 0};
    pats[4] = '{17'b0000000_011_0110011, 17'h1FFFF, A_SLTU, 1'b0, 1'b1, 1'b0, 0};
    pats[5] = '{17'b0000000_000_0010011, 17'h003FF, A_ADD,  1'b1, 1'b1, 1'b0, 0};
    pats[6] = '{17'b0000000_000_0110111, 17'h0007F, A_ADD,  1'b0, 1'b1, 1'b1, 0};
    pats[7] = '{17'b0000000_000_1100011, 17'h003FF, A_SUB,  1'b0, 1'b0, 1'b0, 1};
    pats[8] = '{17'b0000000_001_1100011, 17'h003FF, A_SUB,  1'b0, 1'b0, 1'b0, 2};
    pats[9] = '{17'b0000000_000_1101111, 17'h0007F, A_ADD,  1'b0, 1'b0, 1'b0, 3};

    // Zero-wait ADDI, then ADD with a 3-cycle ack delay.
    resetSeq();
    runInstr(legalRand(5), 0, 1'b0, 0);
    runInstr(legalRand(0), 3, 1'b0, 0);
    // Branches and jump.
    runInstr(legalRand(7), 0, 1'b1, 0);
    runInstr(legalRand(8), 1, 1'b1, 0);
    runInstr(legalRand(8), 0, 1'b0, 0);
    runInstr(legalRand(9), 2, 1'b1, 0);
    // Illegal opcode parks in trap.
    runInstr({7'h00, 3'h0, 7'h7F}, 0, 1'b0, 0);
    trapIdle(20);
    // Timeout with no ack, then ack arriving exactly at the limit.
    resetSeq();
    runInstr(legalRand(0), 10, 1'b0, 0);
    trapIdle(3);
    resetSeq();
    runInstr(legalRand(1), int'(TMO) - 1, 1'b0, 0);
    // Three retirements, then reset mid-execute.
    resetSeq();
    runInstr(legalRand(2), 0, 1'b0, 0);
    runInstr(legalRand(6), 1, 1'b0, 0);
    runInstr(legalRand(4), 0, 1'b0, 0);
    runInstr(legalRand(3), 0, 1'b0, 1);
    runInstr(legalRand(5), 0, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 99) < 80) f = legalRand(int'($urandom_range(0, 9)));
      else f = 17'($urandom);
      if ($urandom_range(0, 9) < 8) w = int'($urandom_range(0, 3));
      else w = int'($urandom_range(3, 6));
      runInstr(f, w, 1'($urandom), ($urandom_range(0, 29) == 0));
      if (trapped) begin
        trapIdle(3);
        resetSeq();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
